// File: rtl/idli_mem_arb_m.sv
// Nibble-serial arbiter/sequencer sharing the 4-bit memory port between
// instruction fetch and load/store; returns read nibbles LSB-first with a valid strobe.
module idli_mem_arb_m (
    input  logic        i_arb_gck,
    input  logic        i_arb_rst,
    input  logic        i_arb_if_req,
    input  logic [15:0] i_arb_if_addr,
    output logic        o_arb_if_gnt,
    output logic [3:0]  o_arb_if_data,
    output logic        o_arb_if_vld,
    input  logic        i_arb_ls_req,
    input  logic        i_arb_ls_wr,
    input  logic [15:0] i_arb_ls_addr,
    input  logic [15:0] i_arb_ls_wdata,
    output logic        o_arb_ls_gnt,
    output logic [3:0]  o_arb_ls_data,
    output logic        o_arb_ls_vld,
    output logic        o_arb_mem_cs,
    output logic        o_arb_mem_oe,
    output logic [3:0]  o_arb_mem_out,
    input  logic [3:0]  i_arb_mem_in
);

    // state  | meaning
    // IDLE   | port free, arbitrate and grant
    // CMD    | drive {3'b000, wr}
    // ADDR   | drive address nibbles, MS first
    // TA     | read turnaround, nobody drives
    // DATA   | write: drive wdata LS first; read: capture memory nibbles
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_TA,
        ST_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        owner_ls_q, owner_ls_d;
    logic        last_ls_q, last_ls_d;
    logic [3:0]  if_data_q, if_data_d;
    logic        if_vld_q, if_vld_d;
    logic [3:0]  ls_data_q, ls_data_d;
    logic        ls_vld_q, ls_vld_d;

    logic        if_gnt, ls_gnt;
    logic        cs, oe, rd_nib;
    logic [3:0]  out;
    logic [3:0]  addr_nib, wdata_nib;

    always_comb begin
        addr_nib = addr_q[15:12];
        case (cnt_q)
            2'd0: addr_nib = addr_q[15:12];
            2'd1: addr_nib = addr_q[11:8];
            2'd2: addr_nib = addr_q[7:4];
            2'd3: addr_nib = addr_q[3:0];
            default: addr_nib = addr_q[15:12];
        endcase
        wdata_nib = wdata_q[3:0];
        case (cnt_q)
            2'd0: wdata_nib = wdata_q[3:0];
            2'd1: wdata_nib = wdata_q[7:4];
            2'd2: wdata_nib = wdata_q[11:8];
            2'd3: wdata_nib = wdata_q[15:12];
            default: wdata_nib = wdata_q[3:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        owner_ls_d = owner_ls_q;
        last_ls_d  = last_ls_q;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        cs         = 1'b0;
        oe         = 1'b0;
        out        = 4'h0;
        rd_nib     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the requester not served last wins.
                if (!i_arb_rst) begin
                    if_gnt = i_arb_if_req && (!i_arb_ls_req || last_ls_q);
                    ls_gnt = i_arb_ls_req && (!i_arb_if_req || !last_ls_q);
                end
                if (if_gnt || ls_gnt) begin
                    state_d    = ST_CMD;
                    cnt_d      = 2'd0;
                    owner_ls_d = ls_gnt;
                    last_ls_d  = ls_gnt;
                    addr_d     = ls_gnt ? i_arb_ls_addr : i_arb_if_addr;
                    wr_d       = ls_gnt && i_arb_ls_wr;
                    wdata_d    = i_arb_ls_wdata;
                end
            end
            ST_CMD: begin
                cs      = 1'b1;
                oe      = 1'b1;
                out     = {3'b000, wr_q};
                cnt_d   = 2'd0;
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                cs    = 1'b1;
                oe    = 1'b1;
                out   = addr_nib;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = wr_q ? ST_DATA : ST_TA;
                end
            end
            ST_TA: begin
                cs      = 1'b1;
                cnt_d   = 2'd0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                cs    = 1'b1;
                oe    = wr_q;
                out   = wr_q ? wdata_nib : 4'h0;
                rd_nib = !wr_q;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        if_vld_d  = rd_nib && !owner_ls_q;
        ls_vld_d  = rd_nib && owner_ls_q;
        if_data_d = if_vld_d ? i_arb_mem_in : 4'h0;
        ls_data_d = ls_vld_d ? i_arb_mem_in : 4'h0;
    end

    always_ff @(posedge i_arb_gck) begin
        if (i_arb_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            wr_q       <= 1'b0;
            owner_ls_q <= 1'b0;
            last_ls_q  <= 1'b1;
            if_data_q  <= 4'h0;
            if_vld_q   <= 1'b0;
            ls_data_q  <= 4'h0;
            ls_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            owner_ls_q <= owner_ls_d;
            last_ls_q  <= last_ls_d;
            if_data_q  <= if_data_d;
            if_vld_q   <= if_vld_d;
            ls_data_q  <= ls_data_d;
            ls_vld_q   <= ls_vld_d;
        end
    end

    assign o_arb_if_gnt  = if_gnt;
    assign o_arb_ls_gnt  = ls_gnt;
    assign o_arb_if_data = if_data_q;
    assign o_arb_if_vld  = if_vld_q;
    assign o_arb_ls_data = ls_data_q;
    assign o_arb_ls_vld  = ls_vld_q;
    assign o_arb_mem_cs  = cs;
    assign o_arb_mem_oe  = oe;
    assign o_arb_mem_out = out;

endmodule

// File: doc/idli_mem_arb_m.md
# idli_mem_arb_m

Nibble-serial memory arbiter and sequencer for the idli core. It shares the single 4-bit external memory port between the instruction-fetch requester and the load/store requester. It serialises each 16-bit transaction into command, address and data nibbles. Fetched nibbles are returned as a 4-bit stream with a valid strobe, which feeds the instruction decoder's `enc`/`enc_vld` inputs directly.

## Interface
Parameters: none (address and data width fixed at 16 bits, nibble width 4).

- i_arb_gck  in  1  clock
- i_arb_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_arb_if_req  in  1  fetch request; held high until granted
- i_arb_if_addr  in  16  fetch word address; valid while i_arb_if_req high
- o_arb_if_gnt  out  1  fetch grant, one-cycle pulse
- o_arb_if_data  out  4  fetched nibble (to decoder enc)
- o_arb_if_vld  out  1  o_arb_if_data valid (to decoder enc_vld)
- i_arb_ls_req  in  1  load/store request; held high until granted
- i_arb_ls_wr  in  1  1 = store, 0 = load; valid with i_arb_ls_req
- i_arb_ls_addr  in  16  load/store word address
- i_arb_ls_wdata  in  16  store data
- o_arb_ls_gnt  out  1  load/store grant, one-cycle pulse
- o_arb_ls_data  out  4  loaded nibble
- o_arb_ls_vld  out  1  o_arb_ls_data valid
- o_arb_mem_cs  out  1  memory select, high for the whole transaction
- o_arb_mem_oe  out  1  1 = arbiter drives o_arb_mem_out
- o_arb_mem_out  out  4  nibble to memory
- i_arb_mem_in  in  4  nibble from memory

## Operation
- States: IDLE, CMD, ADDR, TA, DATA. A 2-bit nibble counter indexes within ADDR and DATA.
- IDLE: cs=0, oe=0. If any request is high, select a winner, pulse its gnt combinationally in this cycle, and go to CMD at the next edge.
  - On that same edge, capture the winner's address, write flag, write data and owner into internal registers.
  - Requesters may drop req or change inputs from the cycle after the grant.
- Arbitration:
  - A single requester always wins.
  - If both request, the winner is the requester not served last, tracked by a last-served flag.
  - The flag resets to "load/store", so fetch wins the first tie.
  - Fetch is always a read; i_arb_if has no write path.
- CMD (1 cycle): cs=1, oe=1, out={3'b000, wr}.
- ADDR (4 cycles): oe=1, out=address nibbles, most-significant nibble first (addr[15:12] … addr[3:0]).
- Write path: ADDR → DATA. oe=1, out=wdata nibbles, least-significant first (wdata[3:0] … wdata[15:12]). Then IDLE.
- Read path: ADDR → TA (1 cycle, cs=1, oe=0, out=0) → DATA (4 cycles, oe=0).
  - Each DATA cycle registers i_arb_mem_in into the owner's data output and sets the owner's vld for the following cycle.
  - Nibbles are least-significant first.
- Only the transaction owner's vld ever asserts. The other requester's data and vld hold 0/low.
- o_arb_mem_out is 0 whenever oe=0.

## Timing
- Grant cycle T0 (IDLE). CMD at T1, ADDR at T2–T5.
- Read: TA at T6, DATA at T7–T10. Owner vld high T8–T11 (4 consecutive cycles). IDLE at T11, so a read occupies the port for 10 cycles.
- Write: DATA at T6–T9, IDLE at T10, so a write occupies the port for 9 cycles. No vld for writes.
- At least one IDLE cycle (cs=0) separates transactions. The earliest next grant is at T11 (read) or T10 (write).
- The read vld of the last nibble (T11) may coincide with a new grant pulse; both are valid.
- Reset (i_arb_rst high at an edge):
  - Next state is IDLE; counter 0; last-served = load/store.
  - cs, oe, out, both data outputs and both vld are 0; both gnt are 0 while reset is high.
- Reset mid-transaction: the transaction is abandoned at the next edge, no further nibbles or vld are produced, and requesters must re-request.
- A request dropped before grant is never served. Requests are not sampled outside IDLE.

## Test plan
- Fetch read: if_req with addr 0x1234, memory returns nibbles 0xD,0xC,0xB,0xA in T7–T10 → gnt at T0; out 0x0,1,2,3,4 at T1–T5; oe=0 at T6; if_vld T8–T11 with data D,C,B,A; cs low at T11.
- Store: ls_req, wr=1, addr 0xBEEF, wdata 0x5A3C → out 0x1,B,E,E,F,C,3,A,5 over T1–T9 with oe=1; no vld; IDLE at T10.
- Simultaneous requests held continuously after reset:
  - Fetch is granted first, then load/store, then fetch again (strict alternation).
  - Each grant lands on the first IDLE cycle after the previous transaction completes.
- Load read with fetch idle: ls_req, wr=0 → ls_vld pulses 4 times, if_vld stays low, if_data stays 0.
- Reset at T4 of a read: cs=0 and oe=0 from T5 and no vld. A fetch request pending at reset release wins the first tie.
- Request withdrawn: if_req high for one cycle during a load/store transaction then dropped → no fetch grant is ever issued.
